// File: rtl/i2s_rx_stereo.sv
// i2s_rx_stereo: oversampled I2S / left-justified stereo receiver.
// Left/right words leave as one pair on a valid/ready handshake.
module i2s_rx_stereo #(
  parameter int WORD_LEN = 16,
  parameter int SLOT_LEN = 32,
  parameter bit LJ_MODE  = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                BCLK,
  input  logic                LRCLK,
  input  logic                ADCDAT,
  output logic [WORD_LEN-1:0] leftData,
  output logic [WORD_LEN-1:0] rightData,
  output logic                outValid,
  input  logic                outReady,
  output logic                frameErr,
  output logic                overrun,
  input  logic                clrErr
);

  localparam int CW = $clog2(SLOT_LEN + 1);
  localparam logic [CW-1:0] WL = CW'(WORD_LEN);
  localparam logic [CW-1:0] SL = CW'(SLOT_LEN);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } state_t;

  logic [1:0] bclkSync;
  logic [1:0] lrSync;
  logic [1:0] datSync;
  logic       bclkLast;

  logic bitStb;
  logic ws;
  logic bitIn;
  logic wsEdge;

  state_t              state, stateNx;
  logic                wsLast, wsLastNx;
  logic [CW-1:0]       bitCnt, cntNx;
  logic [WORD_LEN-1:0] shiftReg, shNx;
  logic [WORD_LEN-1:0] leftStage, leftStageNx;
  logic [WORD_LEN-1:0] leftNx, rightNx;
  logic                validNx, feNx, ovNx;

  logic                wordDone;
  logic                shortSlot;
  logic                pairOffer;
  logic [WORD_LEN-1:0] word;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bclkSync <= '0;
      lrSync   <= '0;
      datSync  <= '0;
      bclkLast <= 1'b0;
    end else begin
      bclkSync <= {bclkSync[0], BCLK};
      lrSync   <= {lrSync[0], LRCLK};
      datSync  <= {datSync[0], ADCDAT};
      bclkLast <= bclkSync[1];
    end
  end

  assign bitStb = bclkSync[1] & ~bclkLast;
  assign ws     = lrSync[1];
  assign bitIn  = datSync[1];
  assign wsEdge = bitStb & (ws != wsLast);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      wsLast    <= 1'b0;
      bitCnt    <= '0;
      shiftReg  <= '0;
      leftStage <= '0;
      leftData  <= '0;
      rightData <= '0;
      outValid  <= 1'b0;
      frameErr  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= stateNx;
      wsLast    <= wsLastNx;
      bitCnt    <= cntNx;
      shiftReg  <= shNx;
      leftStage <= leftStageNx;
      leftData  <= leftNx;
      rightData <= rightNx;
      outValid  <= validNx;
      frameErr  <= feNx;
      overrun   <= ovNx;
    end
  end

  always_comb begin
    stateNx     = state;
    wsLastNx    = wsLast;
    cntNx       = bitCnt;
    shNx        = shiftReg;
    leftStageNx = leftStage;
    leftNx      = leftData;
    rightNx     = rightData;
    validNx     = outValid;
    feNx        = frameErr;
    ovNx        = overrun;
    wordDone    = 1'b0;
    shortSlot   = 1'b0;
    pairOffer   = 1'b0;
    word        = '0;

    if (bitStb) begin
      wsLastNx = ws;
      if (state != IDLE) begin
        // In I2S the bit on the edge strobe still closes the old slot
        if (!wsEdge || !LJ_MODE) begin
          if (cntNx < WL) begin
            shNx     = {shNx[WORD_LEN-2:0], bitIn};
            wordDone = (cntNx == WL - ONE);
            word     = shNx;
          end
          if (cntNx != SL) begin
            cntNx = cntNx + ONE;
          end
        end
        if (wsEdge && (cntNx < WL)) begin
          shortSlot = 1'b1;
          wordDone  = 1'b1;
          word      = shNx << (WL - cntNx);
        end
        if (wordDone) begin
          if (state == LEFT) begin
            leftStageNx = word;
          end else begin
            pairOffer = 1'b1;
          end
        end
      end
      if (wsEdge) begin
        cntNx = '0;
        shNx  = '0;
        if (!ws) begin
          stateNx = LEFT;
        end else if (state != IDLE) begin
          stateNx = RIGHT;
        end
        if (LJ_MODE && (stateNx != IDLE)) begin
          shNx  = {{(WORD_LEN-1){1'b0}}, bitIn};
          cntNx = ONE;
        end
      end
    end

    if (clrErr) begin
      feNx = 1'b0;
      ovNx = 1'b0;
    end
    if (shortSlot) begin
      feNx = 1'b1;
    end

    if (outValid && outReady) begin
      validNx = 1'b0;
    end
    if (pairOffer) begin
      if (!outValid || outReady) begin
        leftNx  = leftStage;
        rightNx = word;
        validNx = 1'b1;
      end else begin
        ovNx = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Bench for i2s_rx_stereo: one I2S and one LJ receiver share the pins.
// A slot-level reference model predicts the pairs each should deliver.
module tb_i2s_rx_stereo;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic BCLK = 1'b0;
  logic LRCLK = 1'b0;
  logic ADCDAT = 1'b0;
  logic outReady = 1'b1;
  logic clrErr = 1'b0;

  logic [15:0] leftI, rightI, leftL, rightL;
  logic validI, validL, feI, feL, ovI, ovL;

  int total = 0;
  int bad = 0;
  bit noise = 1'b0;

  logic wsQ[$];
  logic ljQ[$];
  logic bitQ[$];
  logic [31:0] gotI[$];
  logic [31:0] gotL[$];
  logic [31:0] expQ[$];
  logic expFe;

  always #5 CLK = ~CLK;

  i2s_rx_stereo #(.WORD_LEN(16), .SLOT_LEN(32), .LJ_MODE(1'b0)) dutI (
    .CLK(CLK), .RST(RST), .BCLK(BCLK), .LRCLK(LRCLK), .ADCDAT(ADCDAT),
    .leftData(leftI), .rightData(rightI), .outValid(validI),
    .outReady(outReady), .frameErr(feI), .overrun(ovI), .clrErr(clrErr)
  );

  i2s_rx_stereo #(.WORD_LEN(16), .SLOT_LEN(32), .LJ_MODE(1'b1)) dutL (
    .CLK(CLK), .RST(RST), .BCLK(BCLK), .LRCLK(LRCLK), .ADCDAT(ADCDAT),
    .leftData(leftL), .rightData(rightL), .outValid(validL),
    .outReady(outReady), .frameErr(feL), .overrun(ovL), .clrErr(clrErr)
  );

  always @(negedge CLK) begin
    if (!RST) begin
      if (validI && outReady) gotI.push_back({leftI, rightI});
      if (validL && outReady) gotL.push_back({leftL, rightL});
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic resetDut();
    RST = 1'b1;
    BCLK = 1'b0;
    LRCLK = 1'b0;
    ADCDAT = 1'b0;
    clrErr = 1'b0;
    repeat (3) @(posedge CLK);
    RST = 1'b0;
    gotI.delete();
    gotL.delete();
    wsQ.delete();
    ljQ.delete();
    bitQ.delete();
    @(posedge CLK);
    #2;
  endtask

  task automatic addSlot(input logic w, input logic [15:0] wd, input int n);
    for (int j = 0; j < n; j++) begin
      wsQ.push_back(w);
      if (j < 16) ljQ.push_back(wd[15-j]);
      else ljQ.push_back(noise ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  task automatic addFrame(input logic [15:0] l, input logic [15:0] r,
                          input int nl, input int nr);
    addSlot(1'b0, l, nl);
    addSlot(1'b1, r, nr);
  endtask

  // I2S alignment delays the data by one BCLK against LRCLK
  task automatic seal(input bit i2s);
    bitQ.delete();
    for (int i = 0; i < ljQ.size(); i++) begin
      if (!i2s) bitQ.push_back(ljQ[i]);
      else if (i == 0) bitQ.push_back(1'b0);
      else bitQ.push_back(ljQ[i-1]);
    end
  endtask

  task automatic driveStream();
    for (int i = 0; i < wsQ.size(); i++) begin
      LRCLK = wsQ[i];
      ADCDAT = bitQ[i];
      #40 BCLK = 1'b1;
      #40 BCLK = 1'b0;
    end
    repeat (12) @(posedge CLK);
    #2;
  endtask

  // Slot view: a slot runs from one LRCLK change to the next; its first
  // data bit is on the change (LJ) or one BCLK later (I2S).
  task automatic model(input bit lj);
    int n;
    int edges[$];
    bit started;
    logic [15:0] lw;
    n = wsQ.size();
    started = 1'b0;
    lw = '0;
    expQ.delete();
    expFe = 1'b0;
    for (int i = 1; i < n; i++)
      if (wsQ[i] != wsQ[i-1]) edges.push_back(i);
    for (int k = 0; k < edges.size(); k++) begin
      int e, s, t, cnt;
      bit hasEnd;
      logic [15:0] w;
      e = edges[k];
      if (!started && wsQ[e]) continue;
      started = 1'b1;
      hasEnd = (k + 1 < edges.size());
      s = lj ? e : e + 1;
      t = hasEnd ? (lj ? edges[k+1] - 1 : edges[k+1]) : n - 1;
      cnt = t - s + 1;
      w = '0;
      for (int j = 0; j < 16; j++)
        if (j < cnt) w[15-j] = bitQ[s+j];
      if (cnt < 16 && !hasEnd) continue;
      if (cnt < 16) expFe = 1'b1;
      if (!wsQ[e]) lw = w;
      else expQ.push_back({lw, w});
    end
  endtask

  task automatic checkRun(input string tag);
    model(1'b0);
    check({tag, " i2s count"}, 64'(gotI.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < gotI.size(); i++)
      check({tag, " i2s pair"}, gotI[i], expQ[i]);
    check({tag, " i2s frameErr"}, feI, expFe);
    check({tag, " i2s overrun"}, ovI, 1'b0);
    model(1'b1);
    check({tag, " lj count"}, 64'(gotL.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < gotL.size(); i++)
      check({tag, " lj pair"}, gotL[i], expQ[i]);
    check({tag, " lj frameErr"}, feL, expFe);
    check({tag, " lj overrun"}, ovL, 1'b0);
  endtask

  initial begin
    resetDut();
    check("reset i2s outs", {leftI, rightI, validI, feI, ovI}, 64'd0);
    check("reset lj outs", {leftL, rightL, validL, feL, ovL}, 64'd0);

    // I2S stream, fixed words
    noise = 1'b0;
    outReady = 1'b1;
    addSlot(1'b1, 16'h0000, 4);
    addFrame(16'hA5C3, 16'h1234, 32, 32);
    addSlot(1'b0, 16'h0000, 32);
    seal(1'b1);
    driveStream();
    checkRun("i2s fixed");
    check("i2s fixed left", leftI, 16'hA5C3);
    check("i2s fixed right", rightI, 16'h1234);
    check("i2s into lj left", leftL, 16'h52E1);
    check("i2s into lj right", rightL, 16'h091A);

    // LJ stream, same words
    resetDut();
    addSlot(1'b1, 16'h0000, 4);
    addFrame(16'hA5C3, 16'h1234, 32, 32);
    addSlot(1'b0, 16'h0000, 32);
    seal(1'b0);
    driveStream();
    checkRun("lj fixed");
    check("lj fixed left", leftL, 16'hA5C3);
    check("lj fixed right", rightL, 16'h1234);
    check("lj into i2s left", leftI, 16'h4B86);
    check("lj into i2s right", rightI, 16'h2468);

    // short right slot of 12 BCLKs
    resetDut();
    addSlot(1'b1, 16'h0000, 4);
    addFrame(16'h5A5A, 16'hABC0, 32, 12);
    addSlot(1'b0, 16'h0000, 32);
    seal(1'b1);
    driveStream();
    checkRun("short");
    check("short right", rightI, 16'hABC0);
    check("short frameErr", feI, 1'b1);
    clrErr = 1'b1;
    @(posedge CLK);
    #1 clrErr = 1'b0;
    check("short clrErr", feI, 1'b0);

    // consumer stalled: second pair dropped
    resetDut();
    outReady = 1'b0;
    addSlot(1'b1, 16'h0000, 4);
    addFrame(16'h1111, 16'h2222, 32, 32);
    addFrame(16'h3333, 16'h4444, 32, 32);
    addSlot(1'b0, 16'h0000, 32);
    seal(1'b1);
    driveStream();
    check("stall pair", {leftI, rightI}, 32'h1111_2222);
    check("stall valid", validI, 1'b1);
    check("stall overrun", ovI, 1'b1);
    check("stall lj overrun", ovL, 1'b1);
    check("stall frameErr", feI, 1'b0);
    clrErr = 1'b1;
    @(posedge CLK);
    #1 clrErr = 1'b0;
    check("stall clrErr", ovI, 1'b0);
    outReady = 1'b1;
    @(posedge CLK);
    #1 outReady = 1'b0;
    check("stall accept", validI, 1'b0);

    // reset in the middle of a left slot
    resetDut();
    addSlot(1'b1, 16'h0000, 4);
    addFrame(16'hBEEF, 16'hCAFE, 32, 32);
    addSlot(1'b0, 16'h7777, 10);
    seal(1'b1);
    driveStream();
    check("midrst pre valid", validI, 1'b1);
    #3 RST = 1'b1;
    #1;
    check("midrst i2s outs", {leftI, rightI, validI, feI, ovI}, 64'd0);
    check("midrst lj outs", {leftL, rightL, validL, feL, ovL}, 64'd0);

    // 100 frames of counter data, random slot lengths
    resetDut();
    outReady = 1'b1;
    noise = 1'b1;
    addSlot(1'b1, 16'h0000, 4);
    for (int k = 0; k < 100; k++)
      addFrame(16'(2 * k), 16'(2 * k + 1),
               $urandom_range(16, 40), $urandom_range(16, 40));
    addSlot(1'b0, 16'h0000, 32);
    seal(1'b1);
    driveStream();
    checkRun("counter");
    check("counter total", 64'(gotI.size()), 64'd100);

    // random LJ stream
    resetDut();
    addSlot(1'b1, 16'(/*seed*/ $urandom), 3);
    for (int k = 0; k < 20; k++)
      addFrame(16'($urandom), 16'($urandom),
               $urandom_range(16, 40), $urandom_range(16, 40));
    addSlot(1'b0, 16'h0000, 32);
    seal(1'b0);
    driveStream();
    checkRun("random lj");

    // random I2S stream with occasional short slots
    resetDut();
    addSlot(1'b1, 16'($urandom), 5);
    for (int k = 0; k < 20; k++)
      addFrame(16'($urandom), 16'($urandom),
               $urandom_range(10, 40), $urandom_range(10, 40));
    addSlot(1'b0, 16'h0000, 32);
    seal(1'b1);
    driveStream();
    checkRun("random short");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
